// File: rtl/prod_accum.sv
// -----------------------------------------------------------------------------
// prod_accum
//
// Burst accumulator for unsigned 16-bit product words. A start request in IDLE
// latches the burst length and clears the running sum. ACCUM then adds every
// valid product. The edge that accepts the last product presents the final sum
// and moves to DONE. The result stays stable until the consumer acknowledges
// it with rd_ack.
//
// Parameters
//   ACC_W  accumulator / result width (17..32)
//   CNT_W  width of the burst-length field; len == 0 means 2^CNT_W products
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   start   in   begin a new burst (honoured only in IDLE)
//   len     in   CNT_W  burst length, 0 encodes 2^CNT_W
//   prodt   in   16     unsigned product word
//   valid   in   prodt is valid this cycle (honoured only in ACCUM)
//   rd_ack  in   consumer has taken the result (honoured only in DONE)
//   acc     out  ACC_W  registered running sum / final result
//   busy    out  burst in progress
//   done    out  acc holds a final burst result
//   ovf     out  sticky carry-out of the current burst
// -----------------------------------------------------------------------------
module prod_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [15:0]      prodt,
    input  logic             valid,
    input  logic             rd_ack,
    output logic [ACC_W-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    // One extra bit so the counter can hold the full 2^CNT_W burst length.
    localparam int REM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [REM_W-1:0] remaining_reg, remaining_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             ovf_reg, ovf_next;

    // Zero-extended add one bit wider than the accumulator.
    // The top bit of sum is the carry out of bit ACC_W-1.
    logic [ACC_W:0]   sum;
    logic [REM_W-1:0] burst_len;

    assign sum = {1'b0, acc_reg} + {{(ACC_W - 15){1'b0}}, prodt};

    // A zero length field encodes the maximum burst of 2^CNT_W products.
    assign burst_len = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            remaining_reg <= remaining_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ovf_reg       <= ovf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        remaining_next = remaining_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        ovf_next       = ovf_reg;

        case (state_reg)
            ST_IDLE: begin
                // valid is deliberately not looked at here, even alongside start.
                if (start) begin
                    remaining_next = burst_len;
                    acc_next       = '0;
                    ovf_next       = 1'b0;
                    busy_next      = 1'b1;
                    done_next      = 1'b0;
                    state_next     = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (valid) begin
                    acc_next       = sum[ACC_W-1:0];
                    remaining_next = remaining_reg - REM_W'(1);
                    if (sum[ACC_W]) begin
                        ovf_next = 1'b1;
                    end
                    // The final accept publishes the result on the same edge.
                    if (remaining_reg == REM_W'(1)) begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Products and start requests are dropped until the result is taken.
                if (rd_ack) begin
                    done_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b0;
            end
        endcase
    end

    assign acc  = acc_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_prod_accum
//
// Two instances of the accumulator share the same stimulus:
//   dut24  uses the default ACC_W = 24
//   dut17  uses ACC_W = 17, so that the overflow behaviour is exercised
// Each burst pushes the hand-computed final {acc, ovf} for each instance into a
// per-instance queue. A monitor pops an entry whenever done rises and compares.
// Direct checks cover reset, busy and done timing, and the DONE/IDLE corner cases.
// -----------------------------------------------------------------------------
module tb_prod_accum;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic [15:0] prodt;
    logic        valid;
    logic        rd_ack;

    logic [23:0] acc24;
    logic        busy24, done24, ovf24;
    logic [16:0] acc17;
    logic        busy17, done17, ovf17;

    exp_t q24[$];
    exp_t q17[$];

    int n_checks = 0;
    int n_pass   = 0;

    prod_accum #(.ACC_W(24), .CNT_W(4)) dut24 (
        .clock(clk), .reset(rst), .start(start), .len(len), .prodt(prodt),
        .valid(valid), .rd_ack(rd_ack),
        .acc(acc24), .busy(busy24), .done(done24), .ovf(ovf24)
    );

    prod_accum #(.ACC_W(17), .CNT_W(4)) dut17 (
        .clock(clk), .reset(rst), .start(start), .len(len), .prodt(prodt),
        .valid(valid), .rd_ack(rd_ack),
        .acc(acc17), .busy(busy17), .done(done17), .ovf(ovf17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] a24, input logic o24,
                            input logic [31:0] a17, input logic o17);
        exp_t e;
        e.acc = a24; e.ovf = o24; q24.push_back(e);
        e.acc = a17; e.ovf = o17; q17.push_back(e);
    endtask

    // Drivers: every input change happens 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] p);
        valid = 1'b1;
        prodt = p;
        tick(1);
        valid = 1'b0;
        prodt = '0;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick(1);
        start = 1'b0;
    endtask

    task automatic ack;
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
    endtask

    // Scoreboard monitors: an entry is popped on every rising edge of done.
    logic done24_prev = 1'b0;
    logic done17_prev = 1'b0;

    always @(negedge clk) begin
        if (done24 && !done24_prev) begin
            if (q24.size() == 0) begin
                check("unexpected_done24", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q24.pop_front();
                check("result24_acc", {8'd0, acc24}, e.acc);
                check("result24_ovf", {31'd0, ovf24}, {31'd0, e.ovf});
                $display("burst24 result acc=%0d ovf=%0d", acc24, ovf24);
            end
        end
        done24_prev = done24;
    end

    always @(negedge clk) begin
        if (done17 && !done17_prev) begin
            if (q17.size() == 0) begin
                check("unexpected_done17", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q17.pop_front();
                check("result17_acc", {15'd0, acc17}, e.acc);
                check("result17_ovf", {31'd0, ovf17}, {31'd0, e.ovf});
                $display("burst17 result acc=%0d ovf=%0d", acc17, ovf17);
            end
        end
        done17_prev = done17;
    end

    // Watchdog: the stimulus is bounded, but never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        len    = '0;
        prodt  = '0;
        valid  = 1'b0;
        rd_ack = 1'b0;
        #1;
        check("reset_acc",  {8'd0, acc24}, 32'd0);
        check("reset_busy", {31'd0, busy24}, 32'd0);
        check("reset_done", {31'd0, done24}, 32'd0);
        check("reset_ovf",  {31'd0, ovf24}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Burst 1: len = 3, products 10, 20, 30 with two idle cycles between them.
        // A valid product that arrives together with start must be ignored.
        push_exp(32'd60, 1'b0, 32'd60, 1'b0);
        valid = 1'b1;
        prodt = 16'd999;
        do_start(4'd3);
        valid = 1'b0;
        check("b1_busy_after_start", {31'd0, busy24}, 32'd1);
        check("b1_acc_cleared", {8'd0, acc24}, 32'd0);
        send(16'd10);
        check("b1_acc_after_1", {8'd0, acc24}, 32'd10);
        // A start request during ACCUM must be ignored.
        start = 1'b1;
        len   = 4'd1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("b1_busy_gap", {31'd0, busy24}, 32'd1);
        send(16'd20);
        check("b1_busy_after_2", {31'd0, busy24}, 32'd1);
        tick(2);
        send(16'd30);
        check("b1_done_on_accept", {31'd0, done24}, 32'd1);
        check("b1_busy_cleared", {31'd0, busy24}, 32'd0);
        check("b1_acc_final", {8'd0, acc24}, 32'd60);
        // Products offered while in DONE are dropped.
        send(16'd500);
        check("b1_acc_stable_done", {8'd0, acc24}, 32'd60);
        check("b1_done_held", {31'd0, done24}, 32'd1);
        ack();
        check("b1_done_after_ack", {31'd0, done24}, 32'd0);
        check("b1_acc_after_ack", {8'd0, acc24}, 32'd60);

        // Burst 2: len = 0 (16 products) of 65025.
        // In the 17-bit instance: 1040400 mod 131072 = 122896, and ovf is set.
        push_exp(32'd1040400, 1'b0, 32'd122896, 1'b1);
        do_start(4'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                check("b2_done_before_last", {31'd0, done24}, 32'd0);
                check("b2_busy_before_last", {31'd0, busy24}, 32'd1);
            end
            send(16'd65025);
        end
        check("b2_done", {31'd0, done24}, 32'd1);
        check("b2_acc", {8'd0, acc24}, 32'h0FE010);
        ack();

        // Burst 3: len = 3, three products of 65025.
        // 195075 fits in 24 bits; in 17 bits it wraps to 64003 and sets ovf.
        push_exp(32'd195075, 1'b0, 32'd64003, 1'b1);
        do_start(4'd3);
        send(16'd65025);
        send(16'd65025);
        send(16'd65025);
        check("b3_ovf17", {31'd0, ovf17}, 32'd1);
        check("b3_done17", {31'd0, done17}, 32'd1);
        ack();

        // Burst 4: len = 4. Reset is asserted between clock edges after 2 accepts.
        do_start(4'd4);
        send(16'd100);
        send(16'd100);
        check("b4_partial_acc", {8'd0, acc24}, 32'd200);
        #2;
        rst = 1'b1;
        #1;
        check("b4_async_acc",  {8'd0, acc24}, 32'd0);
        check("b4_async_busy", {31'd0, busy24}, 32'd0);
        check("b4_async_done", {31'd0, done24}, 32'd0);
        check("b4_async_ovf",  {31'd0, ovf17}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Fresh burst after the reset: len = 1, product 7.
        push_exp(32'd7, 1'b0, 32'd7, 1'b0);
        do_start(4'd1);
        send(16'd7);
        check("b5_done", {31'd0, done24}, 32'd1);
        check("b5_acc", {8'd0, acc24}, 32'd7);

        // In DONE, start, valid and rd_ack arrive together:
        // return to IDLE, keep acc, and do not start a new burst.
        start  = 1'b1;
        valid  = 1'b1;
        rd_ack = 1'b1;
        len    = 4'd2;
        prodt  = 16'd9;
        tick(1);
        start  = 1'b0;
        valid  = 1'b0;
        rd_ack = 1'b0;
        check("b6_done_cleared", {31'd0, done24}, 32'd0);
        check("b6_busy", {31'd0, busy24}, 32'd0);
        check("b6_acc_kept", {8'd0, acc24}, 32'd7);
        // rd_ack in IDLE has no effect.
        ack();
        tick(2);
        check("b6_idle_busy", {31'd0, busy24}, 32'd0);
        check("b6_idle_acc", {8'd0, acc24}, 32'd7);

        check("q24_drained", q24.size(), 32'd0);
        check("q17_drained", q17.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and result width in bits (legal range 17..32).
REQ-002 Parameter CNT_W, default 4: width of the burst-length field.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-005 Port start, input, 1: request to begin a new accumulation burst.
REQ-006 Port len, input, CNT_W: number of products in the burst; 0 means 2^CNT_W.
REQ-007 Port prodt, input, 16: unsigned product word from the upstream multiplier.
REQ-008 Port valid, input, 1: prodt is valid this cycle.
REQ-009 Port rd_ack, input, 1: consumer has taken the result.
REQ-010 Port acc, output, ACC_W: registered running sum and final result.
REQ-011 Port busy, output, 1: high while a burst is in progress.
REQ-012 Port done, output, 1: acc holds a final burst result.
REQ-013 Port ovf, output, 1: sticky carry-out flag for the current burst.

Function
REQ-014 The block SHALL implement exactly three states: IDLE, ACCUM and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, busy=0 and done=0; acc and ovf SHALL hold their last values.
REQ-016 In IDLE, start=1 SHALL latch len (0 maps to 2^CNT_W) into a remaining counter, clear acc and ovf to 0, set busy=1 and enter ACCUM on that edge.
REQ-017 In IDLE, valid SHALL be ignored, including when it arrives in the same cycle as start.
REQ-018 In ACCUM, on each edge with valid=1: acc <= (acc + zero-extended prodt) mod 2^ACC_W, and the remaining counter decrements by 1.
REQ-019 In ACCUM, a carry out of bit ACC_W-1 on any accepted add SHALL set ovf=1; ovf stays 1 until the next start.
REQ-020 In ACCUM, cycles with valid=0 SHALL leave acc, ovf and the counter unchanged; gaps of any length are legal.
REQ-021 On the edge that accepts the product with remaining=1, acc SHALL take the final sum, busy SHALL clear, done SHALL set and the state SHALL move to DONE (zero added latency after the final accept).
REQ-022 In ACCUM and DONE, start SHALL be ignored.
REQ-023 In DONE, valid SHALL be ignored (products dropped), and acc, ovf and done SHALL stay stable until rd_ack.
REQ-024 In DONE, rd_ack=1 SHALL clear done and return to IDLE on that edge; a simultaneous start SHALL be ignored.
REQ-025 rd_ack outside DONE SHALL have no effect.
REQ-026 The maximum burst of 2^CNT_W products of 255*255 SHALL NOT overflow at the default ACC_W=24.

Reset
REQ-027 While reset=1, and immediately on its assertion (independent of clock): state=IDLE, acc=0, busy=0, done=0, ovf=0, remaining counter=0.
REQ-028 Reset asserted mid-burst SHALL discard the partial sum; the next start after release SHALL begin a fresh burst.

Verification
REQ-029 Reset check: assert reset asynchronously between clock edges -> acc=0, busy=0, done=0, ovf=0 before the next edge.
REQ-030 len=3, products 10, 20, 30 with 2 idle cycles between them -> done=1 with acc=60 on the third accept edge, busy=1 throughout the burst, ovf=0.
REQ-031 len=0, 16 consecutive products of 65025 -> acc=1040400 (0x0FE010), ovf=0, done set on the 16th accept.
REQ-032 ACC_W=17, len=3, three products of 65025 -> acc=64003, ovf=1, done=1.
REQ-033 len=4, reset asserted after 2 accepts -> outputs cleared immediately; a new start with len=1 and product 7 -> acc=7, done=1.
REQ-034 In DONE, drive start=1, valid=1 and rd_ack=1 in the same cycle -> next state IDLE, done=0, acc unchanged, no new burst started.
